// File: rtl/frame_config_pkg.sv
// ----------------------------------------------------------------------------
// frame_config_pkg
// Shared definitions for the frame configuration writer:
//   - cfg_state_e   : writer FSM states
//   - SyncWord      : opens a configuration session
//   - DesyncWord    : closes a session (only honoured where a header is expected)
//   - Hdr*          : bit positions of the column/frame fields in a header word
//   - state_accepts : which states take a word from the bitstream source
// ----------------------------------------------------------------------------
package frame_config_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StChk,
        StStrobe,
        StHold
    } cfg_state_e;

    localparam logic [31:0] SyncWord   = 32'hFAB0_FAB1;
    localparam logic [31:0] DesyncWord = 32'hFAB0_FAB0;

    // Header layout: [15:8] column, [7:0] frame.
    localparam int unsigned HdrColLsb   = 8;
    localparam int unsigned HdrFrameLsb = 0;
    localparam int unsigned HdrFieldW   = 8;

    // The strobe and hold states never take a word; every other state does.
    function automatic logic state_accepts(cfg_state_e s);
        return (s == StIdle) || (s == StHdr) || (s == StData) || (s == StChk);
    endfunction

endpackage

// File: rtl/frame_strobe_decode.sv
// ----------------------------------------------------------------------------
// frame_strobe_decode
// Turns the addressed column/frame of the frame being committed into a
// registered one-hot FrameStrobe pulse. The pulse is one cycle long because
// fire_i is only high on the single cycle the writer enters its strobe state.
// Ports:
//   clk_i     configuration clock
//   rst_ni    asynchronous active-low reset
//   col_i     header column field
//   frame_i   header frame field
//   valid_i   frame may be committed (address in range, checksum good)
//   fire_i    commit this cycle; strobe appears on the next cycle
//   strobe_o  bit c*MaxFramesPerCol+f drives column c, frame f
// ----------------------------------------------------------------------------
module frame_strobe_decode
    import frame_config_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumColumns      = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [HdrFieldW-1:0]                  col_i,
    input  logic [HdrFieldW-1:0]                  frame_i,
    input  logic                                  valid_i,
    input  logic                                  fire_i,
    output logic [MaxFramesPerCol*NumColumns-1:0] strobe_o
);

    localparam int unsigned StrobeW = MaxFramesPerCol * NumColumns;

    logic [StrobeW-1:0] strobe_d;
    logic [StrobeW-1:0] strobe_q;

    // Out-of-range addresses match no line, so they produce an all-zero vector.
    always_comb begin
        strobe_d = '0;
        for (int c = 0; c < int'(NumColumns); c++) begin
            for (int f = 0; f < int'(MaxFramesPerCol); f++) begin
                if (fire_i && valid_i && (col_i == HdrFieldW'(c)) &&
                    (frame_i == HdrFieldW'(f))) begin
                    strobe_d[c*int'(MaxFramesPerCol)+f] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_config_writer.sv
// ----------------------------------------------------------------------------
// frame_config_writer
// Configuration-port end of the frame interface. Accepts a bitstream word
// stream over valid/ready, assembles one frame of NumRows words into
// FrameData and fires a one-cycle FrameStrobe into the addressed
// column/frame. Session framing: SyncWord opens, DesyncWord (in place of a
// header) closes.
//
// Optional feature (macro FRAME_WRITER_CHECKSUM_EN): after the last data
// row one extra word is accepted that must equal the XOR of the frame's data
// words; a mismatch sets cfg_error and suppresses the strobe.
//
// Ports:
//   CLK          configuration clock
//   resetn       asynchronous active-low reset
//   cfg_data     bitstream word
//   cfg_valid    word valid
//   cfg_ready    word accepted when cfg_valid & cfg_ready (depends on state only)
//   FrameData    row r at [(r+1)*FrameBitsPerRow-1 : r*FrameBitsPerRow]
//   FrameStrobe  column c frame f at bit c*MaxFramesPerCol+f
//   cfg_active   high between SYNC and DESYNC
//   cfg_error    sticky per session: bad address (or bad checksum) seen
// ----------------------------------------------------------------------------
module frame_config_writer
    import frame_config_pkg::*;
#(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumRows         = 16,
    parameter int unsigned NumColumns      = 16
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic [FrameBitsPerRow-1:0]            cfg_data,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
    output logic                                  cfg_active,
    output logic                                  cfg_error
);

    localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
    localparam int unsigned DataW   = FrameBitsPerRow * NumRows;

    cfg_state_e                 state_q, state_d;
    logic [RowW-1:0]            row_cnt_q, row_cnt_d;
    logic [DataW-1:0]           frame_data_q, frame_data_d;
    logic [HdrFieldW-1:0]       col_q, col_d;
    logic [HdrFieldW-1:0]       frm_q, frm_d;
    logic                       frame_valid_q, frame_valid_d;
    logic                       active_q, active_d;
    logic                       error_q, error_d;
    logic                       ready_q, ready_d;
`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] chk_acc_q, chk_acc_d;
`endif

    logic                       accept;
    logic [HdrFieldW-1:0]       hdr_col;
    logic [HdrFieldW-1:0]       hdr_frm;
    logic                       hdr_in_range;
    logic                       strobe_fire;

    assign accept       = cfg_valid && ready_q;
    assign hdr_col      = cfg_data[HdrColLsb +: HdrFieldW];
    assign hdr_frm      = cfg_data[HdrFrameLsb +: HdrFieldW];
    assign hdr_in_range = (32'(hdr_col) < NumColumns) && (32'(hdr_frm) < MaxFramesPerCol);

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        frame_data_d  = frame_data_q;
        col_d         = col_q;
        frm_d         = frm_q;
        frame_valid_d = frame_valid_q;
        active_d      = active_q;
        error_d       = error_q;
`ifdef FRAME_WRITER_CHECKSUM_EN
        chk_acc_d     = chk_acc_q;
`endif

        case (state_q)
            StIdle: begin
                if (accept && (cfg_data == FrameBitsPerRow'(SyncWord))) begin
                    state_d  = StHdr;
                    active_d = 1'b1;
                    error_d  = 1'b0;
                end
            end

            StHdr: begin
                if (accept) begin
                    if (cfg_data == FrameBitsPerRow'(DesyncWord)) begin
                        state_d  = StIdle;
                        active_d = 1'b0;
                    end else begin
                        // A bad address still consumes its data rows so the
                        // stream stays aligned; only the strobe is withheld.
                        col_d         = hdr_col;
                        frm_d         = hdr_frm;
                        frame_valid_d = hdr_in_range;
                        if (!hdr_in_range) begin
                            error_d = 1'b1;
                        end
                        row_cnt_d = '0;
                        state_d   = StData;
                    end
                end
            end

            StData: begin
                if (accept) begin
                    frame_data_d[32'(row_cnt_q)*FrameBitsPerRow +: FrameBitsPerRow] = cfg_data;
`ifdef FRAME_WRITER_CHECKSUM_EN
                    chk_acc_d = (row_cnt_q == '0) ? cfg_data : (chk_acc_q ^ cfg_data);
`endif
                    // Counter parks on the last row rather than wrapping.
                    if (row_cnt_q == LastRow) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StStrobe;
`endif
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end

`ifdef FRAME_WRITER_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    if (cfg_data != chk_acc_q) begin
                        error_d       = 1'b1;
                        frame_valid_d = 1'b0;
                    end
                    state_d = StStrobe;
                end
            end
`endif

            StStrobe: state_d = StHold;

            // Extra cycle with FrameData frozen gives the latches hold time.
            StHold:   state_d = StHdr;

            default:  state_d = StIdle;
        endcase
    end

    // Registered so cfg_ready never sees cfg_valid combinationally and is 0 in reset.
    assign ready_d = state_accepts(state_d);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            row_cnt_q     <= '0;
            frame_data_q  <= '0;
            col_q         <= '0;
            frm_q         <= '0;
            frame_valid_q <= 1'b0;
            active_q      <= 1'b0;
            error_q       <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            frame_data_q  <= frame_data_d;
            col_q         <= col_d;
            frm_q         <= frm_d;
            frame_valid_q <= frame_valid_d;
            active_q      <= active_d;
            error_q       <= error_d;
            ready_q       <= ready_d;
        end
    end

`ifdef FRAME_WRITER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            chk_acc_q <= '0;
        end else begin
            chk_acc_q <= chk_acc_d;
        end
    end
`endif

    // The decoder registers its output, so it is fired on the transition into
    // the strobe state and the pulse lines up with that state.
    assign strobe_fire = (state_d == StStrobe);

    frame_strobe_decode #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumColumns      (NumColumns)
    ) u_strobe_decode (
        .clk_i    (CLK),
        .rst_ni   (resetn),
        .col_i    (col_q),
        .frame_i  (frm_q),
        .valid_i  (frame_valid_d),
        .fire_i   (strobe_fire),
        .strobe_o (FrameStrobe)
    );

    assign cfg_ready  = ready_q;
    assign FrameData  = frame_data_q;
    assign cfg_active = active_q;
    assign cfg_error  = error_q;

endmodule

// File: tb/tb_frame_config_writer.sv
module tb_frame_config_writer;

    localparam int FBPR = 32;
    localparam int MAXF = 20;
    localparam int NR   = 16;
    localparam int NC   = 16;
    localparam int SW   = MAXF * NC;
    localparam int DW   = FBPR * NR;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

`ifdef FRAME_WRITER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    typedef logic [31:0] frame_t [NR];

    logic            CLK = 1'b0;
    logic            resetn = 1'b0;
    logic [FBPR-1:0] cfg_data = '0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [DW-1:0]   FrameData;
    logic [SW-1:0]   FrameStrobe;
    logic            cfg_active;
    logic            cfg_error;

    frame_config_writer #(
        .FrameBitsPerRow (FBPR),
        .MaxFramesPerCol (MAXF),
        .NumRows         (NR),
        .NumColumns      (NC)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .cfg_active  (cfg_active),
        .cfg_error   (cfg_error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc_cyc = 0;

    // Every cycle with any strobe bit set is logged with the data seen then.
    logic [SW-1:0] strobe_log [$];
    logic [DW-1:0] data_log   [$];
    int            cyc_log    [$];

    // Model state / expectations for the most recent frame.
    bit            err_model = 1'b0;
    int            exp_n_strobes;
    logic [SW-1:0] exp_vec;
    logic [DW-1:0] exp_data = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (FrameStrobe !== '0) begin
            strobe_log.push_back(FrameStrobe);
            data_log.push_back(FrameData);
            cyc_log.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] xor_words(input frame_t w);
        logic [31:0] x = '0;
        for (int r = 0; r < NR; r++) x = x ^ w[r];
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after the word was taken.
    task automatic send_word(input logic [31:0] w, input bit stall);
        int budget;
        budget = 0;
        if (stall) begin
            cfg_valid = 1'b0;
            cfg_data  = $urandom;
            @(negedge CLK);
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && budget < 100) begin
            @(negedge CLK);
            budget++;
        end
        if (budget >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: cfg_ready stayed %b, required 1 within 100 cycles",
                     cfg_ready);
        end
        @(negedge CLK);
        last_acc_cyc = cyc;
        cfg_valid = 1'b0;
    endtask

    function automatic bit pick_stall(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 1) == 1);
    endfunction

    // Sends header + rows (+ check word), then builds the model's expectation.
    task automatic do_frame(input logic [31:0] hdr, input frame_t w, input logic [31:0] chk,
                            input int mode);
        int col, frm;
        bit ok;
        strobe_log.delete();
        data_log.delete();
        cyc_log.delete();
        send_word(hdr, pick_stall(mode));
        for (int r = 0; r < NR; r++) send_word(w[r], pick_stall(mode));
        if (ChkEn) send_word(chk, pick_stall(mode));
        repeat (3) @(negedge CLK);
        col = int'(hdr[15:8]);
        frm = int'(hdr[7:0]);
        ok  = (col < NC) && (frm < MAXF) && (!ChkEn || chk == xor_words(w));
        if (!ok) err_model = 1'b1;
        exp_n_strobes = ok ? 1 : 0;
        exp_vec = '0;
        if (ok) exp_vec[col*MAXF+frm] = 1'b1;
        exp_data = '0;
        for (int r = 0; r < NR; r++) exp_data = exp_data | (DW'(w[r]) << (r * FBPR));
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        cfg_valid = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++; if (FrameStrobe !== '0) begin n_fail++;
            $display("FAIL reset_strobe: got %0h required 0", FrameStrobe); end
        n_checks++; if (FrameData !== '0) begin n_fail++;
            $display("FAIL reset_data: got %0h required 0", FrameData); end
        n_checks++; if (cfg_active !== 1'b0) begin n_fail++;
            $display("FAIL reset_active: got %b required 0", cfg_active); end
        n_checks++; if (cfg_error !== 1'b0) begin n_fail++;
            $display("FAIL reset_error: got %b required 0", cfg_error); end
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_ready: got %b required 0", cfg_ready); end
        resetn = 1'b1;
        @(negedge CLK);
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++;
            $display("FAIL idle_ready: got %b required 1", cfg_ready); end
    endtask

    task automatic test_basic;
        frame_t w;
        send_word(32'h1234_5678, 1'b0);   // not SYNC: discarded in IDLE
        n_checks++; if (cfg_active !== 1'b0) begin n_fail++;
            $display("FAIL idle_discard_active: got %b required 0", cfg_active); end
        send_word(SYNC, 1'b0);
        err_model = 1'b0;
        n_checks++; if (cfg_active !== 1'b1) begin n_fail++;
            $display("FAIL sync_active: got %b required 1", cfg_active); end
        for (int r = 0; r < NR; r++) w[r] = 32'(r + 1);
        do_frame(32'h0000_0305, w, xor_words(w), 0);
        n_checks++; if (strobe_log.size() != 1) begin n_fail++;
            $display("FAIL basic_strobe_count: got %0d required 1", strobe_log.size());
        end else begin
            n_checks++; if (strobe_log[0] !== exp_vec) begin n_fail++;
                $display("FAIL basic_strobe_vec: got %0h required %0h", strobe_log[0], exp_vec); end
            n_checks++; if (strobe_log[0][65] !== 1'b1) begin n_fail++;
                $display("FAIL basic_strobe_bit65: got %b required 1", strobe_log[0][65]); end
            n_checks++; if (cyc_log[0] != last_acc_cyc) begin n_fail++;
                $display("FAIL basic_strobe_cycle: got %0d required %0d", cyc_log[0], last_acc_cyc); end
            n_checks++; if (data_log[0] !== exp_data) begin n_fail++;
                $display("FAIL basic_data_at_strobe: got %0h required %0h", data_log[0], exp_data); end
        end
        n_checks++; if (FrameData[31:0] !== 32'h1) begin n_fail++;
            $display("FAIL basic_row0: got %0h required 1", FrameData[31:0]); end
        n_checks++; if (FrameData[DW-1 -: 32] !== 32'h10) begin n_fail++;
            $display("FAIL basic_row15: got %0h required 10", FrameData[DW-1 -: 32]); end
        n_checks++; if (cfg_error !== 1'b0) begin n_fail++;
            $display("FAIL basic_error: got %b required 0", cfg_error); end
    endtask

    task automatic test_bad_header;
        frame_t w;
        logic [31:0] hdrs [3];
        hdrs[0] = 32'h0000_1000;   // column 16
        hdrs[1] = 32'h0000_0014;   // frame 20
        hdrs[2] = 32'h0000_0F13;   // column 15 frame 19: last valid line
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                send_word(DESYNC, 1'b0);
                send_word(SYNC, 1'b0);
                err_model = 1'b0;
                n_checks++; if (cfg_error !== 1'b0) begin n_fail++;
                    $display("FAIL resync_clears_error: got %b required 0", cfg_error); end
            end
            for (int r = 0; r < NR; r++) w[r] = $urandom;
            do_frame(hdrs[i], w, xor_words(w), 0);
            n_checks++; if (strobe_log.size() != exp_n_strobes) begin n_fail++;
                $display("FAIL hdr%0d_strobe_count: got %0d required %0d", i,
                         strobe_log.size(), exp_n_strobes);
            end else if (exp_n_strobes == 1) begin
                n_checks++; if (strobe_log[0] !== exp_vec) begin n_fail++;
                    $display("FAIL hdr%0d_strobe_vec: got %0h required %0h", i,
                             strobe_log[0], exp_vec); end
            end
            n_checks++; if (FrameData !== exp_data) begin n_fail++;
                $display("FAIL hdr%0d_data: got %0h required %0h", i, FrameData, exp_data); end
            n_checks++; if (cfg_error !== err_model) begin n_fail++;
                $display("FAIL hdr%0d_error: got %b required %b", i, cfg_error, err_model); end
        end
    endtask

    task automatic test_stall;
        frame_t w;
        for (int r = 0; r < NR; r++) w[r] = $urandom;
        do_frame(32'h0000_0305, w, xor_words(w), 1);
        n_checks++; if (strobe_log.size() != 1) begin n_fail++;
            $display("FAIL stall_strobe_count: got %0d required 1", strobe_log.size());
        end else begin
            n_checks++; if (strobe_log[0] !== exp_vec) begin n_fail++;
                $display("FAIL stall_strobe_vec: got %0h required %0h", strobe_log[0], exp_vec); end
            n_checks++; if (data_log[0] !== exp_data) begin n_fail++;
                $display("FAIL stall_data_at_strobe: got %0h required %0h", data_log[0], exp_data); end
        end
        n_checks++; if (FrameData !== exp_data) begin n_fail++;
            $display("FAIL stall_data: got %0h required %0h", FrameData, exp_data); end
    endtask

    task automatic test_random;
        frame_t w;
        logic [31:0] hdr, chk;
        for (int i = 0; i < 12; i++) begin
            hdr = {16'h0, 8'($urandom_range(0, 17)), 8'($urandom_range(0, 22))};
            for (int r = 0; r < NR; r++) w[r] = $urandom;
            chk = xor_words(w);
            if ($urandom_range(0, 3) == 0) chk = chk ^ (32'h1 << $urandom_range(0, 31));
            do_frame(hdr, w, chk, 2);
            n_checks++; if (strobe_log.size() != exp_n_strobes) begin n_fail++;
                $display("FAIL rand%0d_strobe_count: got %0d required %0d hdr %0h", i,
                         strobe_log.size(), exp_n_strobes, hdr);
            end else if (exp_n_strobes == 1) begin
                n_checks++; if (strobe_log[0] !== exp_vec) begin n_fail++;
                    $display("FAIL rand%0d_strobe_vec: got %0h required %0h", i,
                             strobe_log[0], exp_vec); end
                n_checks++; if (cyc_log[0] != last_acc_cyc) begin n_fail++;
                    $display("FAIL rand%0d_strobe_cycle: got %0d required %0d", i,
                             cyc_log[0], last_acc_cyc); end
            end
            n_checks++; if (FrameData !== exp_data) begin n_fail++;
                $display("FAIL rand%0d_data: got %0h required %0h", i, FrameData, exp_data); end
            n_checks++; if (cfg_error !== err_model) begin n_fail++;
                $display("FAIL rand%0d_error: got %b required %b", i, cfg_error, err_model); end
        end
    endtask

`ifdef FRAME_WRITER_CHECKSUM_EN
    task automatic test_checksum;
        frame_t w;
        send_word(DESYNC, 1'b0);
        send_word(SYNC, 1'b0);
        err_model = 1'b0;
        for (int r = 0; r < NR; r++) w[r] = 32'(r + 1);
        do_frame(32'h0000_0305, w, 32'h10, 0);
        n_checks++; if (strobe_log.size() != 1) begin n_fail++;
            $display("FAIL chk_good_strobe_count: got %0d required 1", strobe_log.size()); end
        n_checks++; if (cfg_error !== 1'b0) begin n_fail++;
            $display("FAIL chk_good_error: got %b required 0", cfg_error); end
        do_frame(32'h0000_0305, w, 32'h11, 0);
        n_checks++; if (strobe_log.size() != 0) begin n_fail++;
            $display("FAIL chk_bad_strobe_count: got %0d required 0", strobe_log.size()); end
        n_checks++; if (cfg_error !== 1'b1) begin n_fail++;
            $display("FAIL chk_bad_error: got %b required 1", cfg_error); end
    endtask
`endif

    task automatic test_desync;
        logic [DW-1:0] held;
        held = FrameData;
        send_word(DESYNC, 1'b0);
        n_checks++; if (cfg_active !== 1'b0) begin n_fail++;
            $display("FAIL desync_active: got %b required 0", cfg_active); end
        strobe_log.delete();
        send_word(32'hDEAD_BEEF, 1'b0);
        send_word(32'h0000_0305, 1'b0);
        for (int r = 0; r < NR + 2; r++) send_word($urandom, 1'b0);
        repeat (3) @(negedge CLK);
        n_checks++; if (strobe_log.size() != 0) begin n_fail++;
            $display("FAIL desync_no_strobe: got %0d strobes required 0", strobe_log.size()); end
        n_checks++; if (cfg_active !== 1'b0) begin n_fail++;
            $display("FAIL desync_stays_idle: got %b required 0", cfg_active); end
        n_checks++; if (FrameData !== held) begin n_fail++;
            $display("FAIL desync_data_held: got %0h required %0h", FrameData, held); end
    endtask

    task automatic test_reset_mid;
        send_word(SYNC, 1'b0);
        err_model = 1'b0;
        send_word(32'h0000_0305, 1'b0);
        for (int r = 0; r < 8; r++) send_word($urandom, 1'b0);
        strobe_log.delete();
        cfg_data  = 32'h0000_1234;
        cfg_valid = 1'b1;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (FrameData !== '0) begin n_fail++;
            $display("FAIL midreset_data: got %0h required 0", FrameData); end
        n_checks++; if (cfg_active !== 1'b0) begin n_fail++;
            $display("FAIL midreset_active: got %b required 0", cfg_active); end
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++;
            $display("FAIL midreset_ready: got %b required 0", cfg_ready); end
        repeat (3) @(negedge CLK);
        resetn = 1'b1;
        repeat (25) @(negedge CLK);
        cfg_valid = 1'b0;
        n_checks++; if (strobe_log.size() != 0) begin n_fail++;
            $display("FAIL midreset_no_strobe: got %0d strobes required 0", strobe_log.size()); end
        n_checks++; if (FrameData !== '0) begin n_fail++;
            $display("FAIL midreset_data_after: got %0h required 0", FrameData); end
        n_checks++; if (cfg_active !== 1'b0) begin n_fail++;
            $display("FAIL midreset_active_after: got %b required 0", cfg_active); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_stall();
        test_random();
`ifdef FRAME_WRITER_CHECKSUM_EN
        test_checksum();
`endif
        test_desync();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
